// File: rtl/sprite_cfg_pkg.sv
// Shared definitions for the sprite configuration controller:
// register map, FSM state codes, shadow register layout and register access helpers.
package sprite_cfg_pkg;

   localparam logic [6:0] REG_X_LO = 7'h00;
   localparam logic [6:0] REG_X_HI = 7'h01;
   localparam logic [6:0] REG_Y_LO = 7'h02;
   localparam logic [6:0] REG_Y_HI = 7'h03;
   localparam logic [6:0] REG_FG   = 7'h04;
   localparam logic [6:0] REG_BG   = 7'h05;
   localparam logic [6:0] REG_CTRL = 7'h06;
   localparam logic [6:0] BMP_BASE = 7'h40;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_CMD  = 3'd1;
   localparam state_t ST_WR   = 3'd2;
   localparam state_t ST_RD   = 3'd3;
   localparam state_t ST_SINK = 3'd4;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [5:0] fg;
      logic [5:0] bg;
      logic       en;
   } shadow_t;

   function automatic shadow_t write_reg(input shadow_t s, input logic [6:0] a, input logic [7:0] d);
      shadow_t r;
      r = s;
      case (a)
         REG_X_LO: r.x[7:0] = d;
         REG_X_HI: r.x[9:8] = d[1:0];
         REG_Y_LO: r.y[7:0] = d;
         REG_Y_HI: r.y[9:8] = d[1:0];
         REG_FG:   r.fg     = d[5:0];
         REG_BG:   r.bg     = d[5:0];
         REG_CTRL: r.en     = d[0];
         default:  r = s;
      endcase
      return r;
   endfunction

   // Reserved and bitmap addresses read back as zero.
   function automatic logic [7:0] read_reg(input shadow_t s, input logic [6:0] a);
      logic [7:0] r;
      case (a)
         REG_X_LO: r = s.x[7:0];
         REG_X_HI: r = {6'd0, s.x[9:8]};
         REG_Y_LO: r = s.y[7:0];
         REG_Y_HI: r = {6'd0, s.y[9:8]};
         REG_FG:   r = {2'd0, s.fg};
         REG_BG:   r = {2'd0, s.bg};
         REG_CTRL: r = {7'd0, s.en};
         default:  r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/spi_cfg_ctrl_if.sv
// SPI pin bundle between an SPI master and the sprite configuration controller.
interface spi_cfg_ctrl_if;
   logic spi_sclk;
   logic spi_mosi;
   logic spi_cs;
   logic spi_miso;

   modport master (output spi_sclk, output spi_mosi, output spi_cs, input spi_miso);
   modport slave  (input spi_sclk, input spi_mosi, input spi_cs, output spi_miso);
endinterface

// File: rtl/spi_byte_if.sv
// SPI mode-0 byte engine: pin synchronisers, edge detect, rx/tx shifters and bit counter.
// Tx shifter is built only when SPI_READBACK_EN is defined.
module spi_byte_if #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       spi_sclk,
   input  logic       spi_mosi,
   input  logic       spi_cs,
   input  logic       tx_load,
   input  logic [7:0] tx_byte,
   output logic       frame_start,
   output logic       frame_end,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       miso
);
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic       sclk_prev_q, sclk_prev_d;
   logic       cs_prev_q, cs_prev_d;
   logic [6:0] rx_shift_q, rx_shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       sclk_s, mosi_s, cs_s, sclk_rise, sclk_fall;

   assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s        = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise   = sclk_s & ~sclk_prev_q & ~cs_s;
   assign sclk_fall   = ~sclk_s & sclk_prev_q & ~cs_s;
   assign frame_start = ~cs_s & cs_prev_q;
   assign frame_end   = cs_s & ~cs_prev_q;
   assign byte_valid  = sclk_rise & (bit_cnt_q == 3'd7);
   assign rx_byte     = {rx_shift_q, mosi_s};

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sclk_prev_d = sclk_s;
      cs_prev_d   = cs_s;
      rx_shift_d  = rx_shift_q;
      bit_cnt_d   = bit_cnt_q;
      // Deselect throws away any partial byte so the next frame starts aligned.
      if (cs_s) begin
         rx_shift_d = '0;
         bit_cnt_d  = '0;
      end else if (sclk_rise) begin
         rx_shift_d = {rx_shift_q[5:0], mosi_s};
         bit_cnt_d  = bit_cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '1;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         rx_shift_q  <= '0;
         bit_cnt_q   <= '0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         cs_sync_q   <= cs_sync_d;
         sclk_prev_q <= sclk_prev_d;
         cs_prev_q   <= cs_prev_d;
         rx_shift_q  <= rx_shift_d;
         bit_cnt_q   <= bit_cnt_d;
      end
   end

`ifdef SPI_READBACK_EN
   logic [7:0] tx_shift_q, tx_shift_d;
   logic       miso_q, miso_d;

   always_comb begin
      tx_shift_d = tx_shift_q;
      miso_d     = miso_q;
      if (cs_s) begin
         tx_shift_d = '0;
         miso_d     = 1'b0;
      end else if (tx_load && sclk_fall) begin
         miso_d     = tx_byte[7];
         tx_shift_d = {tx_byte[6:0], 1'b0};
      end else if (tx_load) begin
         tx_shift_d = tx_byte;
      end else if (sclk_fall) begin
         miso_d     = tx_shift_q[7];
         tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_shift_q <= '0;
         miso_q     <= 1'b0;
      end else begin
         tx_shift_q <= tx_shift_d;
         miso_q     <= miso_d;
      end
   end

   assign miso = miso_q;
`else
   logic unused_tx;
   assign unused_tx = ^{tx_load, tx_byte, sclk_fall};
   assign miso      = 1'b0;
`endif

endmodule

// File: rtl/spi_cfg_ctrl.sv
// SPI-slave configuration controller for the one-sprite SVGA engine; shadow registers commit on next_frame.
// Optional register readback over MISO is enabled by defining SPI_READBACK_EN.
module spi_cfg_ctrl
   import sprite_cfg_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int BMP_AW      = 6
) (
   input  logic              clk,
   input  logic              reset_n,
   spi_cfg_ctrl_if.slave     spi,
   input  logic              next_frame,
   output logic [9:0]        sprite_x,
   output logic [9:0]        sprite_y,
   output logic [5:0]        color_fg,
   output logic [5:0]        color_bg,
   output logic              sprite_en,
   output logic              bmp_we,
   output logic [BMP_AW-1:0] bmp_addr,
   output logic [7:0]        bmp_wdata
);
   state_t            state_q, state_d;
   logic [6:0]        addr_q, addr_d;
   shadow_t           shadow_q, shadow_d;
   shadow_t           active_q, active_d;
   logic              commit_pending_q, commit_pending_d;
   logic              bmp_we_q, bmp_we_d;
   logic [BMP_AW-1:0] bmp_addr_q, bmp_addr_d;
   logic [7:0]        bmp_wdata_q, bmp_wdata_d;
   logic              shadow_wr, tx_load;
   logic [7:0]        tx_byte, rx_byte;
   logic              frame_start, frame_end, byte_valid, miso_raw;

   spi_byte_if #(.SYNC_STAGES(SYNC_STAGES)) u_byte (
      .clk         (clk),
      .reset_n     (reset_n),
      .spi_sclk    (spi.spi_sclk),
      .spi_mosi    (spi.spi_mosi),
      .spi_cs      (spi.spi_cs),
      .tx_load     (tx_load),
      .tx_byte     (tx_byte),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .byte_valid  (byte_valid),
      .rx_byte     (rx_byte),
      .miso        (miso_raw)
   );

   always_comb begin
      state_d          = state_q;
      addr_d           = addr_q;
      shadow_d         = shadow_q;
      active_d         = active_q;
      commit_pending_d = commit_pending_q;
      bmp_we_d         = 1'b0;
      bmp_addr_d       = bmp_addr_q;
      bmp_wdata_d      = bmp_wdata_q;
      shadow_wr        = 1'b0;
      tx_load          = 1'b0;
      tx_byte          = 8'h00;
      case (state_q)
         ST_IDLE: if (frame_start) state_d = ST_CMD;
         ST_CMD: if (byte_valid) begin
            addr_d = rx_byte[6:0];
            if (rx_byte[7]) begin
`ifdef SPI_READBACK_EN
               state_d = ST_RD;
               tx_load = 1'b1;
               tx_byte = read_reg(shadow_q, rx_byte[6:0]);
`else
               state_d = ST_SINK;
`endif
            end else begin
               state_d = ST_WR;
            end
         end
         ST_WR: if (byte_valid) begin
            addr_d = addr_q + 7'd1;
            if (addr_q >= BMP_BASE) begin
               bmp_we_d    = 1'b1;
               bmp_addr_d  = addr_q[BMP_AW-1:0];
               bmp_wdata_d = rx_byte;
            end else if (addr_q <= REG_CTRL) begin
               shadow_wr = 1'b1;
               shadow_d  = write_reg(shadow_q, addr_q, rx_byte);
            end
         end
`ifdef SPI_READBACK_EN
         // Prefetch the following address so its MSB is ready on the next SCLK fall.
         ST_RD: if (byte_valid) begin
            addr_d  = addr_q + 7'd1;
            tx_load = 1'b1;
            tx_byte = read_reg(shadow_q, addr_q + 7'd1);
         end
`endif
         default: state_d = state_q;
      endcase
      if (frame_end) state_d = ST_IDLE;
      // Commit copies the pre-write shadow; a same-cycle write keeps the commit pending.
      if (next_frame && commit_pending_q) begin
         active_d         = shadow_q;
         commit_pending_d = 1'b0;
      end
      if (shadow_wr) commit_pending_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         addr_q           <= '0;
         shadow_q         <= '0;
         active_q         <= '0;
         commit_pending_q <= 1'b0;
         bmp_we_q         <= 1'b0;
         bmp_addr_q       <= '0;
         bmp_wdata_q      <= '0;
      end else begin
         state_q          <= state_d;
         addr_q           <= addr_d;
         shadow_q         <= shadow_d;
         active_q         <= active_d;
         commit_pending_q <= commit_pending_d;
         bmp_we_q         <= bmp_we_d;
         bmp_addr_q       <= bmp_addr_d;
         bmp_wdata_q      <= bmp_wdata_d;
      end
   end

   assign sprite_x  = active_q.x;
   assign sprite_y  = active_q.y;
   assign color_fg  = active_q.fg;
   assign color_bg  = active_q.bg;
   assign sprite_en = active_q.en;
   assign bmp_we    = bmp_we_q;
   assign bmp_addr  = bmp_addr_q;
   assign bmp_wdata = bmp_wdata_q;

`ifdef SPI_READBACK_EN
   // Raw chip select gates MISO so the pin is quiet the moment the master deselects.
   assign spi.spi_miso = miso_raw & (state_q == ST_RD) & ~spi.spi_cs;
`else
   logic unused_miso;
   assign unused_miso  = miso_raw;
   assign spi.spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// Directed bench for spi_cfg_ctrl: SPI mode-0 master tasks, bitmap-write scoreboard, commit checks.
module tb_spi_cfg_ctrl;
   localparam int SYNC = 2;
   localparam int HALF = 4;
`ifdef SPI_READBACK_EN
   localparam bit MISO_ALWAYS0 = 1'b0;
`else
   localparam bit MISO_ALWAYS0 = 1'b1;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic       next_frame;
   logic [9:0] sprite_x, sprite_y;
   logic [5:0] color_fg, color_bg;
   logic       sprite_en, bmp_we;
   logic [5:0] bmp_addr;
   logic [7:0] bmp_wdata;
   logic [7:0] rx;
   int         total = 0;
   int         bad = 0;
   int         bmp_pulses = 0;
   int         pulses_before;
   bit         miso_bad = 1'b0;
   logic [13:0] exp_bmp[$];

   spi_cfg_ctrl_if spi_if ();

   spi_cfg_ctrl #(.SYNC_STAGES(SYNC), .BMP_AW(6)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .spi        (spi_if),
      .next_frame (next_frame),
      .sprite_x   (sprite_x),
      .sprite_y   (sprite_y),
      .color_fg   (color_fg),
      .color_bg   (color_bg),
      .sprite_en  (sprite_en),
      .bmp_we     (bmp_we),
      .bmp_addr   (bmp_addr),
      .bmp_wdata  (bmp_wdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every bitmap strobe must match the oldest queued write.
   always @(negedge clk) begin
      if (bmp_we === 1'b1) begin
         bmp_pulses++;
         check("bmp_expected", 32'(exp_bmp.size() != 0), 32'd1);
         if (exp_bmp.size() != 0)
            check("bmp_write", 32'({bmp_addr, bmp_wdata}), 32'(exp_bmp.pop_front()));
      end
      if (spi_if.spi_miso === 1'b1 && (spi_if.spi_cs === 1'b1 || MISO_ALWAYS0)) miso_bad = 1'b1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic xfer(input logic [7:0] tx, input int nbits, input bit nf_last, output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_if.spi_mosi = tx[i];
         repeat (HALF) @(negedge clk);
         r = {r[6:0], spi_if.spi_miso};
         spi_if.spi_sclk = 1'b1;
         for (int c = 0; c < HALF; c++) begin
            @(negedge clk);
            next_frame = nf_last && (i == 0) && (c == SYNC - 1);
         end
         spi_if.spi_sclk = 1'b0;
      end
   endtask

   task automatic send(input logic [7:0] b);
      logic [7:0] r;
      xfer(b, 8, 1'b0, r);
   endtask

   task automatic cs_low();
      spi_if.spi_cs = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (HALF) @(negedge clk);
      spi_if.spi_cs   = 1'b1;
      spi_if.spi_mosi = 1'b0;
      repeat (3 * HALF) @(negedge clk);
   endtask

   task automatic pulse_nf();
      @(negedge clk) next_frame = 1'b1;
      @(negedge clk) next_frame = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset_n         = 1'b0;
      next_frame      = 1'b0;
      spi_if.spi_cs   = 1'b1;
      spi_if.spi_sclk = 1'b0;
      spi_if.spi_mosi = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_pos", 32'({sprite_x, sprite_y}), 32'd0);
      check("reset_misc", 32'({color_fg, color_bg, sprite_en, bmp_we, bmp_addr, bmp_wdata, spi_if.spi_miso}), 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // X = 0x234 stays hidden until next_frame
      cs_low(); send(8'h00); send(8'h34); send(8'h02); cs_high();
      check("t1_x_before", 32'(sprite_x), 32'd0);
      check("t1_pend_before", 32'(dut.commit_pending_q), 32'd1);
      pulse_nf();
      check("t1_x_after", 32'(sprite_x), 32'h234);
      check("t1_pend_after", 32'(dut.commit_pending_q), 32'd0);

      // full bitmap burst
      pulses_before = bmp_pulses;
      cs_low(); send(8'h40);
      for (int i = 0; i < 64; i++) begin
         exp_bmp.push_back({6'(i), 8'(i)});
         send(8'(i));
      end
      cs_high();
      check("t2_pulses", 32'(bmp_pulses - pulses_before), 32'd64);
      check("t2_q_empty", 32'(exp_bmp.size()), 32'd0);
      check("t2_active", 32'({sprite_x, sprite_y}), 32'({10'h234, 10'h000}));
      check("t2_pend", 32'(dut.commit_pending_q), 32'd0);

      // address wrap from 0x7F into X_LO
      cs_low(); send(8'h7F);
      exp_bmp.push_back({6'd63, 8'hAA});
      send(8'hAA); send(8'h11); cs_high();
      check("t3_q_empty", 32'(exp_bmp.size()), 32'd0);
      check("t3_x_before", 32'(sprite_x), 32'h234);
      pulse_nf();
      check("t3_x_after", 32'(sprite_x), 32'h211);

      // aborted bytes and reserved writes do nothing
      pulses_before = bmp_pulses;
      cs_low(); send(8'h40); xfer(8'hFF, 5, 1'b0, rx); cs_high();
      cs_low(); send(8'h05); xfer(8'hFF, 5, 1'b0, rx); cs_high();
      cs_low(); send(8'h07); send(8'h55); cs_high();
      check("t4_no_bmp", 32'(bmp_pulses - pulses_before), 32'd0);
      check("t4_pend", 32'(dut.commit_pending_q), 32'd0);
      cs_low(); send(8'h04); send(8'h3F); cs_high();
      pulse_nf();
      check("t4_fg", 32'(color_fg), 32'h3F);
      check("t4_bg", 32'(color_bg), 32'h00);

      // FG byte completes on the same clk as next_frame
      cs_low(); send(8'h05); send(8'h0A); cs_high();
      cs_low(); send(8'h04); xfer(8'h15, 8, 1'b1, rx); cs_high();
      check("t5_fg_same", 32'(color_fg), 32'h3F);
      check("t5_bg_commit", 32'(color_bg), 32'h0A);
      check("t5_pend", 32'(dut.commit_pending_q), 32'd1);
      pulse_nf();
      check("t5_fg_next", 32'(color_fg), 32'h15);

      // Y = 0x1FF, CTRL, then readback of Y
      cs_low(); send(8'h02); send(8'hFF); send(8'h01); cs_high();
      cs_low(); send(8'h06); send(8'h03); cs_high();
      cs_low(); send(8'h82);
      xfer(8'h00, 8, 1'b0, rx);
      check("t6_rd0", 32'(rx), MISO_ALWAYS0 ? 32'h00 : 32'hFF);
      xfer(8'h00, 8, 1'b0, rx);
      check("t6_rd1", 32'(rx), MISO_ALWAYS0 ? 32'h00 : 32'h01);
      cs_high();
      check("t6_miso_quiet", 32'(miso_bad), 32'd0);
      check("t6_y_before", 32'(sprite_y), 32'd0);
      pulse_nf();
      check("t6_y_after", 32'(sprite_y), 32'h1FF);
      check("t6_en", 32'(sprite_en), 32'd1);
      check("t6_fg_kept", 32'(color_fg), 32'h15);

      // reset in the middle of a transfer
      cs_low(); send(8'h00); xfer(8'hFF, 4, 1'b0, rx);
      reset_n = 1'b0;
      @(negedge clk);
      check("t7_pos", 32'({sprite_x, sprite_y}), 32'd0);
      check("t7_misc", 32'({color_fg, color_bg, sprite_en, dut.commit_pending_q}), 32'd0);
      spi_if.spi_cs   = 1'b1;
      spi_if.spi_sclk = 1'b0;
      spi_if.spi_mosi = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      pulse_nf();
      check("t7_after", 32'({sprite_x, sprite_y}), 32'd0);
      check("t7_q_empty", 32'(exp_bmp.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
